check_scanner_seq: RTL

- Sequential, parametrised attack scanner for an N x N board.
- On a start request it snapshots the board and the target king square, then checks leaper attackers (pawn, knight) in one cycle.
- It then walks the eight sliding rays one square per cycle, stopping each ray at its first occupied square.
- Reports check, a per-source attack mask and an attacker count; sits between the move-validation FSM and the board register file.

---
 rtl/chess_pkg.sv | 36 +++
 rtl/attack_classify.sv | 24 ++
 rtl/check_scanner_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - piece, direction and attack-mask definitions shared by the check scanner
package chess_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_t;

    localparam int COLOR_BIT = 3;

    // Row y+1 is "down", so north steps toward row 0.
    typedef enum logic [2:0] {
        DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
    } dir_t;

    localparam int DIR_DX [8] = '{ 0,  1,  1,  1,  0, -1, -1, -1};
    localparam int DIR_DY [8] = '{-1, -1,  0,  1,  1,  1,  0, -1};

    localparam int KNIGHT_DX [8] = '{ 1,  2,  2,  1, -1, -2, -2, -1};
    localparam int KNIGHT_DY [8] = '{-2, -1,  1,  2,  2,  1, -1, -2};

    localparam int MASK_KNIGHT = 8;
    localparam int MASK_PAWN   = 9;

    localparam int MAX_ATTACKERS = 8 + 2 + 8;

    function automatic int count_width();
        return $clog2(MAX_ATTACKERS + 1);
    endfunction

endpackage

// File: rtl/attack_classify.sv
// rtl/attack_classify.sv - classifies the first occupied square of a sliding ray
module attack_classify
    import chess_pkg::*;
(
    input  logic [3:0] sq,
    input  logic       king_colour,
    input  logic       diag,
    output logic       occupied,
    output logic       hit,
    output logic       blocks
);

    logic [2:0] kind;
    logic       enemy;
    logic       slider_match;

    assign kind         = sq[2:0];
    assign occupied     = (kind != EMPTY);
    assign enemy        = (sq[COLOR_BIT] != king_colour);
    assign slider_match = (kind == QUEEN) || (diag ? (kind == BISHOP) : (kind == ROOK));
    assign hit          = occupied && enemy && slider_match;
    assign blocks       = occupied && !hit;

endmodule

// File: rtl/check_scanner_seq.sv
// rtl/check_scanner_seq.sv - sequential king attack scanner (leapers in one cycle, rays one square per cycle)
// Define CHECK_SCANNER_EARLY_EXIT_EN to stop at the first attacker found.
module check_scanner_seq
    import chess_pkg::*;
#(
    parameter int N   = 8,
    parameter int CW  = $clog2(N),
    parameter int ACW = count_width()
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    king_x,
    input  logic [CW-1:0]    king_y,
    input  logic [N*N*4-1:0] board,
    output logic             busy,
    output logic             done,
    output logic             check,
    output logic [9:0]       attack_mask,
    output logic [ACW-1:0]   attacker_count,
    output logic             invalid
);

    typedef enum logic [1:0] {S_IDLE, S_LEAP, S_RAY, S_DONE} state_t;

    localparam int              IW        = $clog2(N * N * 4);
    localparam logic [CW:0]     DIST_ONE  = {{CW{1'b0}}, 1'b1};
    localparam logic [ACW-1:0]  COUNT_ONE = {{(ACW-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [N*N*4-1:0]   board_q;
    logic [CW-1:0]      kx_q, ky_q;
    dir_t               dir_q, dir_d;
    logic [CW:0]        dist_q, dist_d;
    logic [9:0]         mask_q, mask_d;
    logic [ACW-1:0]     count_q, count_d;
    logic               check_q, check_d;
    logic               invalid_q, invalid_d;
    logic               accept;

    function automatic logic on_board(input int x, input int y);
        return (x >= 0) && (x < N) && (y >= 0) && (y < N);
    endfunction

    // Off-board squares read as empty so leaper offsets never match across an edge.
    function automatic logic [3:0] sq_at(input logic [N*N*4-1:0] b, input int x, input int y);
        logic [IW-1:0] base;
        if (!on_board(x, y)) begin
            return 4'd0;
        end
        base = IW'((x * N + y) * 4);
        return b[base +: 4];
    endfunction

    logic [3:0] king_sq;
    logic       king_colour;

    assign accept      = (state_q == S_IDLE) && start;
    assign king_sq     = sq_at(board_q, int'(kx_q), int'(ky_q));
    assign king_colour = king_sq[COLOR_BIT];

    logic [3:0] knight_cnt;
    logic [1:0] pawn_cnt;

    always_comb begin
        logic [3:0] s;
        int         pawn_dy;
        s          = 4'd0;
        knight_cnt = '0;
        pawn_cnt   = '0;
        pawn_dy    = king_colour ? 1 : -1;
        for (int k = 0; k < 8; k++) begin
            s = sq_at(board_q, int'(kx_q) + KNIGHT_DX[k], int'(ky_q) + KNIGHT_DY[k]);
            if (s[2:0] == KNIGHT && s[COLOR_BIT] != king_colour) begin
                knight_cnt = knight_cnt + 4'd1;
            end
        end
        for (int k = -1; k <= 1; k += 2) begin
            s = sq_at(board_q, int'(kx_q) + k, int'(ky_q) + pawn_dy);
            if (s[2:0] == PAWN && s[COLOR_BIT] != king_colour) begin
                pawn_cnt = pawn_cnt + 2'd1;
            end
        end
    end

    int         ray_x, ray_y;
    logic [3:0] ray_sq;
    logic       next_on;
    logic       ray_occupied;
    logic       ray_hit;
    logic       unused_blocks;

    assign ray_x   = int'(kx_q) + DIR_DX[dir_q] * int'(dist_q);
    assign ray_y   = int'(ky_q) + DIR_DY[dir_q] * int'(dist_q);
    assign ray_sq  = sq_at(board_q, ray_x, ray_y);
    assign next_on = on_board(ray_x + DIR_DX[dir_q], ray_y + DIR_DY[dir_q]);

    attack_classify u_classify (
        .sq          (ray_sq),
        .king_colour (king_colour),
        .diag        (dir_q[0]),
        .occupied    (ray_occupied),
        .hit         (ray_hit),
        .blocks      (unused_blocks)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        dist_d    = dist_q;
        mask_d    = mask_q;
        count_d   = count_q;
        check_d   = check_q;
        invalid_d = invalid_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LEAP;
                    dir_d     = DIR_N;
                    dist_d    = DIST_ONE;
                    mask_d    = '0;
                    count_d   = '0;
                    check_d   = 1'b0;
                    invalid_d = 1'b0;
                end
            end
            S_LEAP: begin
                dir_d  = DIR_N;
                dist_d = DIST_ONE;
                // An out-of-range king coordinate also reads as empty here.
                if (king_sq[2:0] != KING) begin
                    invalid_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    mask_d[MASK_KNIGHT] = (knight_cnt != 4'd0);
                    mask_d[MASK_PAWN]   = (pawn_cnt != 2'd0);
                    count_d             = ACW'(knight_cnt) + ACW'(pawn_cnt);
                    state_d             = S_RAY;
`ifdef CHECK_SCANNER_EARLY_EXIT_EN
                    if (knight_cnt != 4'd0 || pawn_cnt != 2'd0) begin
                        count_d = COUNT_ONE;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_RAY: begin
                if (ray_hit) begin
                    mask_d[{1'b0, dir_q}] = 1'b1;
                    count_d               = count_q + COUNT_ONE;
                end
                // A ray whose first square is off-board reads empty with next_on low.
                if (ray_occupied || !next_on) begin
                    dist_d = DIST_ONE;
                    if (dir_q == DIR_NW) begin
                        state_d = S_DONE;
                    end else begin
                        dir_d = dir_t'(dir_q + 3'd1);
                    end
                end else begin
                    dist_d = dist_q + DIST_ONE;
                end
`ifdef CHECK_SCANNER_EARLY_EXIT_EN
                if (ray_hit) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE) begin
            check_d = |mask_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            board_q   <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            dir_q     <= DIR_N;
            dist_q    <= DIST_ONE;
            mask_q    <= '0;
            count_q   <= '0;
            check_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            dist_q    <= dist_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
            check_q   <= check_d;
            invalid_q <= invalid_d;
            if (accept) begin
                board_q <= board;
                kx_q    <= king_x;
                ky_q    <= king_y;
            end
        end
    end

    assign busy           = (state_q == S_LEAP) || (state_q == S_RAY);
    assign done           = (state_q == S_DONE);
    assign check          = check_q;
    assign attack_mask    = mask_q;
    assign attacker_count = count_q;
    assign invalid        = invalid_q;

endmodule
